mem_island_rsp_buffer: RTL and testbench

// - Multi-channel, credit-based response buffer between mem-protocol requestors and memory_island_core ports.
// - Core returns exactly one in-order rvalid per granted request after a fixed latency, with no backpressure.
// - This block adds rready backpressure on the requestor side.
// - It limits in-flight plus buffered responses to BufDepth per channel, so no response is ever dropped.
// - It also returns a write-ack flag with each response.

---
 rtl/mem_island_rsp_buf_pkg.sv | 18 +
 rtl/mem_island_rsp_buf_chan.sv | 167 ++++++++++++++++
 rtl/mem_island_rsp_buffer.sv | 70 +++++++
 tb/tb_mem_island_rsp_buffer.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_island_rsp_buf_pkg.sv
// Shared constants and sizing helpers for the memory-island response buffer.
package mem_island_rsp_buf_pkg;

  localparam int StallCntWidth = 32;

  typedef logic [StallCntWidth-1:0] stall_cnt_t;

  // Counter width able to hold the values 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // FIFO pointer width; a depth-1 FIFO still gets a 1-bit pointer.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_island_rsp_buf_chan.sv
// One channel of the response buffer: credit gate, request-tag FIFO and response data FIFO.
// The stall counter exists only when MEM_ISLAND_RSP_BUF_STATS_EN is defined.
module mem_island_rsp_buf_chan
  import mem_island_rsp_buf_pkg::*;
#(
  parameter int AddrWidth   = 32,
  parameter int DataWidth   = 64,
  parameter int BufDepth    = 4,
  parameter bit FallThrough = 1'b1,
  parameter int StrbWidth   = DataWidth / 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_i,
  output logic                     gnt_o,
  input  logic [AddrWidth-1:0]     addr_i,
  input  logic                     we_i,
  input  logic [DataWidth-1:0]     wdata_i,
  input  logic [StrbWidth-1:0]     strb_i,
  output logic                     rvalid_o,
  input  logic                     rready_i,
  output logic [DataWidth-1:0]     rdata_o,
  output logic                     rwe_o,
  output logic                     mem_req_o,
  input  logic                     mem_gnt_i,
  output logic [AddrWidth-1:0]     mem_addr_o,
  output logic                     mem_we_o,
  output logic [DataWidth-1:0]     mem_wdata_o,
  output logic [StrbWidth-1:0]     mem_strb_o,
  input  logic                     mem_rvalid_i,
  input  logic [DataWidth-1:0]     mem_rdata_i,
  output logic                     err_o,
  output logic [StallCntWidth-1:0] stall_cnt_o
);

  localparam int CntW = cnt_width(BufDepth);
  localparam int PtrW = ptr_width(BufDepth);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(BufDepth - 1);
  localparam logic [CntW:0]   DepthVal = (CntW + 1)'(BufDepth);

  logic [CntW-1:0] inflight_q, inflight_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [PtrW-1:0] dat_wr_q, dat_wr_d, dat_rd_q, dat_rd_d;
  logic            err_q, err_d;

  logic                 tag_mem [BufDepth];
  logic [DataWidth:0]   dat_mem [BufDepth];

  logic [CntW:0]      occupancy;
  logic               credit_ok;
  logic               grant;
  logic               rsp_ok;
  logic               fifo_empty;
  logic               ft_active;
  logic               push;
  logic               pop;
  logic               tag_head;
  logic [DataWidth:0] head;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  // Credit is derived from registered state only, so rready_i never reaches mem_req_o.
  always_comb begin
    occupancy  = {1'b0, inflight_q} + {1'b0, count_q};
    credit_ok  = (occupancy < DepthVal);
    grant      = req_i & mem_gnt_i & credit_ok & ~rst_i;
    rsp_ok     = mem_rvalid_i & (inflight_q != '0);
    fifo_empty = (count_q == '0);
    tag_head   = tag_mem[tag_rd_q];
    ft_active  = FallThrough & fifo_empty & rsp_ok;
    pop        = ~fifo_empty & rready_i;
    push       = rsp_ok & ~(ft_active & rready_i);
    head       = fifo_empty ? {tag_head, mem_rdata_i} : dat_mem[dat_rd_q];
  end

  always_comb begin
    rvalid_o    = ~fifo_empty | ft_active;
    rdata_o     = rvalid_o ? head[DataWidth-1:0] : '0;
    rwe_o       = rvalid_o & head[DataWidth];
    mem_req_o   = req_i & credit_ok & ~rst_i;
    gnt_o       = mem_gnt_i & credit_ok & ~rst_i;
    mem_addr_o  = rst_i ? '0 : addr_i;
    mem_we_o    = we_i & ~rst_i;
    mem_wdata_o = rst_i ? '0 : wdata_i;
    mem_strb_o  = rst_i ? '0 : strb_i;
    err_o       = err_q;
  end

  always_comb begin
    inflight_d = inflight_q;
    case ({grant, rsp_ok})
      2'b10:   inflight_d = inflight_q + CntW'(1);
      2'b01:   inflight_d = inflight_q - CntW'(1);
      default: inflight_d = inflight_q;
    endcase

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    tag_wr_d = grant  ? ptr_inc(tag_wr_q) : tag_wr_q;
    tag_rd_d = rsp_ok ? ptr_inc(tag_rd_q) : tag_rd_q;
    dat_wr_d = push   ? ptr_inc(dat_wr_q) : dat_wr_q;
    dat_rd_d = pop    ? ptr_inc(dat_rd_q) : dat_rd_q;
    // A response with nothing outstanding cannot be matched to a request: drop and flag it.
    err_d    = err_q | (mem_rvalid_i & (inflight_q == '0));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      inflight_q <= '0;
      count_q    <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      dat_wr_q   <= '0;
      dat_rd_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      count_q    <= count_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
      dat_wr_q   <= dat_wr_d;
      dat_rd_q   <= dat_rd_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (grant) begin
      tag_mem[tag_wr_q] <= we_i;
    end
    if (push) begin
      dat_mem[dat_wr_q] <= {tag_head, mem_rdata_i};
    end
  end

`ifdef MEM_ISLAND_RSP_BUF_STATS_EN
  stall_cnt_t stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (req_i & ~credit_ok & (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + StallCntWidth'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: rtl/mem_island_rsp_buffer.sv
// Credit-based response buffer in front of memory_island_core ports, one independent lane per channel.
// Define MEM_ISLAND_RSP_BUF_STATS_EN to enable the per-channel credit-stall counters.
module mem_island_rsp_buffer
  import mem_island_rsp_buf_pkg::*;
#(
  parameter int NumChannels = 2,
  parameter int AddrWidth   = 32,
  parameter int DataWidth   = 64,
  parameter int BufDepth    = 4,
  parameter bit FallThrough = 1'b1,
  localparam int StrbWidth  = DataWidth / 8
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic [NumChannels-1:0]                    req_i,
  output logic [NumChannels-1:0]                    gnt_o,
  input  logic [NumChannels-1:0][AddrWidth-1:0]     addr_i,
  input  logic [NumChannels-1:0]                    we_i,
  input  logic [NumChannels-1:0][DataWidth-1:0]     wdata_i,
  input  logic [NumChannels-1:0][StrbWidth-1:0]     strb_i,
  output logic [NumChannels-1:0]                    rvalid_o,
  input  logic [NumChannels-1:0]                    rready_i,
  output logic [NumChannels-1:0][DataWidth-1:0]     rdata_o,
  output logic [NumChannels-1:0]                    rwe_o,
  output logic [NumChannels-1:0]                    mem_req_o,
  input  logic [NumChannels-1:0]                    mem_gnt_i,
  output logic [NumChannels-1:0][AddrWidth-1:0]     mem_addr_o,
  output logic [NumChannels-1:0]                    mem_we_o,
  output logic [NumChannels-1:0][DataWidth-1:0]     mem_wdata_o,
  output logic [NumChannels-1:0][StrbWidth-1:0]     mem_strb_o,
  input  logic [NumChannels-1:0]                    mem_rvalid_i,
  input  logic [NumChannels-1:0][DataWidth-1:0]     mem_rdata_i,
  output logic [NumChannels-1:0]                    err_o,
  output logic [NumChannels-1:0][StallCntWidth-1:0] stall_cnt_o
);

  for (genvar gi = 0; gi < NumChannels; gi++) begin : g_chan
    mem_island_rsp_buf_chan #(
      .AddrWidth  (AddrWidth),
      .DataWidth  (DataWidth),
      .BufDepth   (BufDepth),
      .FallThrough(FallThrough),
      .StrbWidth  (StrbWidth)
    ) u_chan (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_i       (req_i[gi]),
      .gnt_o       (gnt_o[gi]),
      .addr_i      (addr_i[gi]),
      .we_i        (we_i[gi]),
      .wdata_i     (wdata_i[gi]),
      .strb_i      (strb_i[gi]),
      .rvalid_o    (rvalid_o[gi]),
      .rready_i    (rready_i[gi]),
      .rdata_o     (rdata_o[gi]),
      .rwe_o       (rwe_o[gi]),
      .mem_req_o   (mem_req_o[gi]),
      .mem_gnt_i   (mem_gnt_i[gi]),
      .mem_addr_o  (mem_addr_o[gi]),
      .mem_we_o    (mem_we_o[gi]),
      .mem_wdata_o (mem_wdata_o[gi]),
      .mem_strb_o  (mem_strb_o[gi]),
      .mem_rvalid_i(mem_rvalid_i[gi]),
      .mem_rdata_i (mem_rdata_i[gi]),
      .err_o       (err_o[gi]),
      .stall_cnt_o (stall_cnt_o[gi])
    );
  end

endmodule

// File: tb/tb_mem_island_rsp_buffer.sv
// Directed bench for mem_island_rsp_buffer: vector table plus hand-written multi-cycle sequences.
// A small fixed-latency core model and per-channel scoreboard check every response handed out.
module tb_mem_island_rsp_buffer;
  import mem_island_rsp_buf_pkg::*;

  localparam int NC = 2;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int SW = 8;
  localparam int BD = 4;
`ifdef MEM_ISLAND_RSP_BUF_STATS_EN
  localparam int ExpStall = 9;
`else
  localparam int ExpStall = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_i;
  logic [NC-1:0]          req_i, gnt_o, we_i, rvalid_o, rready_i, rwe_o;
  logic [NC-1:0]          mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i, err_o;
  logic [NC-1:0][AW-1:0]  addr_i, mem_addr_o;
  logic [NC-1:0][DW-1:0]  wdata_i, rdata_o, mem_wdata_o, mem_rdata_i;
  logic [NC-1:0][SW-1:0]  strb_i, mem_strb_o;
  logic [NC-1:0][31:0]    stall_cnt_o;

  logic [0:0]             d1_req, d1_gnt, d1_we, d1_rvalid, d1_rready, d1_rwe;
  logic [0:0]             d1_mem_req, d1_mem_gnt, d1_mem_we, d1_mem_rvalid, d1_err;
  logic [0:0][AW-1:0]     d1_addr, d1_mem_addr;
  logic [0:0][DW-1:0]     d1_wdata, d1_rdata, d1_mem_wdata, d1_mem_rdata;
  logic [0:0][SW-1:0]     d1_strb, d1_mem_strb;
  logic [0:0][31:0]       d1_stall;

  mem_island_rsp_buffer #(
    .NumChannels(NC), .AddrWidth(AW), .DataWidth(DW), .BufDepth(BD), .FallThrough(1'b1)
  ) u_dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i), .we_i(we_i),
    .wdata_i(wdata_i), .strb_i(strb_i), .rvalid_o(rvalid_o), .rready_i(rready_i),
    .rdata_o(rdata_o), .rwe_o(rwe_o), .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o),
    .mem_strb_o(mem_strb_o), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .err_o(err_o), .stall_cnt_o(stall_cnt_o)
  );

  mem_island_rsp_buffer #(
    .NumChannels(1), .AddrWidth(AW), .DataWidth(DW), .BufDepth(1), .FallThrough(1'b1)
  ) u_dut1 (
    .clk_i(clk), .rst_i(rst_i), .req_i(d1_req), .gnt_o(d1_gnt), .addr_i(d1_addr), .we_i(d1_we),
    .wdata_i(d1_wdata), .strb_i(d1_strb), .rvalid_o(d1_rvalid), .rready_i(d1_rready),
    .rdata_o(d1_rdata), .rwe_o(d1_rwe), .mem_req_o(d1_mem_req), .mem_gnt_i(d1_mem_gnt),
    .mem_addr_o(d1_mem_addr), .mem_we_o(d1_mem_we), .mem_wdata_o(d1_mem_wdata),
    .mem_strb_o(d1_mem_strb), .mem_rvalid_i(d1_mem_rvalid), .mem_rdata_i(d1_mem_rdata),
    .err_o(d1_err), .stall_cnt_o(d1_stall)
  );

  typedef struct {
    int          ch;
    logic        we;
    logic [31:0] addr;
    logic        exp_rwe;
    logic        chk_data;
    logic [63:0] exp_rdata;
  } vec_t;

  typedef struct { int due; logic [63:0] data; } pend_t;
  typedef struct { logic rwe; logic [63:0] data; } rsp_t;

  pend_t   pend_q[NC][$];
  rsp_t    exp_q[NC][$];
  int      n_tests = 0;
  int      n_fail  = 0;
  int      cyc     = 0;
  int      lat     = 2;
  logic [NC-1:0] inject_rv = '0;
  vec_t    vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  // One clock: record grants and consumed responses, then drive the core model for the next cycle.
  task automatic tick();
    pend_t p;
    rsp_t  e;
    #1;
    for (int ch = 0; ch < NC; ch++) begin
      if (mem_req_o[ch] && mem_gnt_i[ch]) begin
        p.due  = cyc + lat;
        p.data = {32'h0, addr_i[ch]};
        pend_q[ch].push_back(p);
        e.rwe  = we_i[ch];
        e.data = {32'h0, addr_i[ch]};
        exp_q[ch].push_back(e);
      end
      if (rvalid_o[ch] && rready_i[ch]) begin
        n_tests++;
        if (exp_q[ch].size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_rsp ch%0d: got rwe=%0b rdata=%h, required no response",
                   ch, rwe_o[ch], rdata_o[ch]);
        end else begin
          e = exp_q[ch].pop_front();
          $display("[TB] ch%0d rsp rwe=%0b rdata=%h", ch, rwe_o[ch], rdata_o[ch]);
          if (rwe_o[ch] !== e.rwe || (!e.rwe && rdata_o[ch] !== e.data)) begin
            n_fail++;
            $display("FAIL scoreboard ch%0d: got rwe=%0b rdata=%h, required rwe=%0b rdata=%h",
                     ch, rwe_o[ch], rdata_o[ch], e.rwe, e.data);
          end
        end
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    for (int ch = 0; ch < NC; ch++) begin
      mem_rvalid_i[ch] = inject_rv[ch];
      mem_rdata_i[ch]  = '0;
      if (pend_q[ch].size() > 0 && pend_q[ch][0].due == cyc) begin
        p = pend_q[ch].pop_front();
        mem_rvalid_i[ch] = 1'b1;
        mem_rdata_i[ch]  = p.data;
      end
    end
    #1;
  endtask

  task automatic check_zero(input string tag);
    for (int ch = 0; ch < NC; ch++) begin
      check($sformatf("%s_gnt%0d", tag, ch),    64'(gnt_o[ch]),       64'h0);
      check($sformatf("%s_mreq%0d", tag, ch),   64'(mem_req_o[ch]),   64'h0);
      check($sformatf("%s_maddr%0d", tag, ch),  64'(mem_addr_o[ch]),  64'h0);
      check($sformatf("%s_mwe%0d", tag, ch),    64'(mem_we_o[ch]),    64'h0);
      check($sformatf("%s_mwdata%0d", tag, ch), mem_wdata_o[ch],      64'h0);
      check($sformatf("%s_mstrb%0d", tag, ch),  64'(mem_strb_o[ch]),  64'h0);
      check($sformatf("%s_rvalid%0d", tag, ch), 64'(rvalid_o[ch]),    64'h0);
      check($sformatf("%s_rdata%0d", tag, ch),  rdata_o[ch],          64'h0);
      check($sformatf("%s_rwe%0d", tag, ch),    64'(rwe_o[ch]),       64'h0);
      check($sformatf("%s_err%0d", tag, ch),    64'(err_o[ch]),       64'h0);
      check($sformatf("%s_stall%0d", tag, ch),  64'(stall_cnt_o[ch]), 64'h0);
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < 50) begin
      tick();
      n++;
    end
    check($sformatf("%s_drained", tag), 64'(exp_q[0].size() + exp_q[1].size()), 64'h0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    int n;
    vecs[0] = '{0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1, 64'h0000_0000_DEAD_BEEF};
    vecs[1] = '{0, 1'b1, 32'h0000_0100, 1'b1, 1'b0, 64'h0};
    vecs[2] = '{1, 1'b0, 32'h1234_5678, 1'b0, 1'b1, 64'h0000_0000_1234_5678};
    vecs[3] = '{1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 64'h0};
    vecs[4] = '{0, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 64'h0};
    vecs[5] = '{1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1, 64'h0000_0000_FFFF_FFFF};

    // Reset with active-looking inputs: every output must stay at zero.
    rst_i        = 1'b1;
    req_i        = '1;
    mem_gnt_i    = '1;
    we_i         = '1;
    addr_i       = {32'hA5A5_0001, 32'h5A5A_0002};
    wdata_i      = {64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
    strb_i       = '1;
    rready_i     = '1;
    mem_rvalid_i = '0;
    mem_rdata_i  = '0;
    d1_req = '0; d1_we = '0; d1_addr = '0; d1_wdata = '0; d1_strb = '0;
    d1_rready = '0; d1_mem_gnt = '1; d1_mem_rvalid = '0; d1_mem_rdata = '0;
    tick();
    tick();
    check_zero("reset");
    req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0; strb_i = '0;
    rst_i = 1'b0;
    tick();
    check("idle_err", 64'(err_o), 64'h0);
    check("idle_rvalid", 64'(rvalid_o), 64'h0);

    // Table: single transactions, pass-through, latency and response contents.
    for (int i = 0; i < 6; i++) begin
      int ch  = vecs[i].ch;
      int oth = 1 - vecs[i].ch;
      req_i[ch]   = 1'b1;
      we_i[ch]    = vecs[i].we;
      addr_i[ch]  = vecs[i].addr;
      wdata_i[ch] = {$urandom, $urandom};
      strb_i[ch]  = 8'($urandom);
      settle();
      check($sformatf("v%0d_gnt", i),    64'(gnt_o[ch]),      64'h1);
      check($sformatf("v%0d_mreq", i),   64'(mem_req_o[ch]),  64'h1);
      check($sformatf("v%0d_maddr", i),  64'(mem_addr_o[ch]), 64'(vecs[i].addr));
      check($sformatf("v%0d_mwe", i),    64'(mem_we_o[ch]),   64'(vecs[i].we));
      check($sformatf("v%0d_mwdata", i), mem_wdata_o[ch],     wdata_i[ch]);
      check($sformatf("v%0d_mstrb", i),  64'(mem_strb_o[ch]), 64'(strb_i[ch]));
      check($sformatf("v%0d_oth_mreq", i), 64'(mem_req_o[oth]), 64'h0);
      tick();
      req_i[ch] = 1'b0;
      n = 1;
      settle();
      while (!rvalid_o[ch] && n < 10) begin
        tick();
        n++;
      end
      check($sformatf("v%0d_latency", i), 64'(n), 64'd2);
      check($sformatf("v%0d_rvalid", i), 64'(rvalid_o[ch]), 64'h1);
      check($sformatf("v%0d_rwe", i), 64'(rwe_o[ch]), 64'(vecs[i].exp_rwe));
      if (vecs[i].chk_data) begin
        check($sformatf("v%0d_rdata", i), rdata_o[ch], vecs[i].exp_rdata);
      end
      check($sformatf("v%0d_oth_rvalid", i), 64'(rvalid_o[oth]), 64'h0);
      tick();
    end
    drain("table");

    // Four writes fill all credits while rready is low; the fifth waits for a pop.
    rready_i[0] = 1'b0;
    req_i[0]    = 1'b1;
    we_i[0]     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr_i[0] = 32'h40 + 32'(i * 4);
      settle();
      check($sformatf("A_gnt%0d", i), 64'(gnt_o[0]), 64'h1);
      tick();
    end
    addr_i[0] = 32'h50;
    for (int j = 0; j < 5; j++) begin
      settle();
      check($sformatf("A_no_gnt%0d", j), 64'(gnt_o[0]), 64'h0);
      check($sformatf("A_no_mreq%0d", j), 64'(mem_req_o[0]), 64'h0);
      check($sformatf("A_hold_rv%0d", j), {62'h0, rvalid_o[0], rwe_o[0]}, 64'h3);
      tick();
    end
    rready_i[0] = 1'b1;
    settle();
    check("A_pop_cycle_no_gnt", 64'(gnt_o[0]), 64'h0);
    tick();
    settle();
    check("A_gnt_after_pop", 64'(gnt_o[0]), 64'h1);
    tick();
    req_i[0] = 1'b0;
    drain("A");

    // Mixed R/W/R traffic with random rready and core grant on both channels.
    lat = 3;
    for (int c = 0; c < 80; c++) begin
      for (int ch = 0; ch < NC; ch++) begin
        req_i[ch]     = ($urandom_range(0, 3) != 0);
        we_i[ch]      = ((c % 3) == 1);
        addr_i[ch]    = $urandom;
        wdata_i[ch]   = {$urandom, $urandom};
        rready_i[ch]  = $urandom_range(0, 1) == 1;
        mem_gnt_i[ch] = ($urandom_range(0, 4) != 0);
      end
      tick();
    end
    req_i     = '0;
    rready_i  = '1;
    mem_gnt_i = '1;
    drain("B");
    check("B_err", 64'(err_o), 64'h0);

    // Stray core response on idle channel 1.
    inject_rv = 2'b10;
    tick();
    inject_rv = 2'b00;
    settle();
    check("C_not_forwarded", 64'(rvalid_o[1]), 64'h0);
    check("C_err_not_yet", 64'(err_o), 64'h0);
    tick();
    check("C_err_set", 64'(err_o), 64'h2);
    repeat (3) tick();
    check("C_err_sticky", 64'(err_o), 64'h2);

    // Reset with three reads in flight; the late responses must be dropped.
    lat = 6;
    req_i[0] = 1'b1;
    we_i[0]  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      addr_i[0] = 32'h200 + 32'(i);
      settle();
      check($sformatf("D_gnt%0d", i), 64'(gnt_o[0]), 64'h1);
      tick();
    end
    rst_i = 1'b1;
    exp_q[0].delete();
    exp_q[1].delete();
    req_i = '1; we_i = '1; addr_i = {32'hCAFE_0001, 32'hCAFE_0002};
    wdata_i = {64'hFFFF, 64'hEEEE}; strb_i = '1;
    settle();
    check_zero("D_rst");
    tick();
    check_zero("D_rst2");
    tick();
    req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0; strb_i = '0;
    rst_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("D_late_rv%0d", i), 64'(rvalid_o[0]), 64'h0);
      tick();
    end
    check("D_err", 64'(err_o), 64'h1);

    // Credit-stall counter on a one-deep buffer with rready held low.
    for (int c = 0; c < 10; c++) begin
      d1_req = 1'b1;
      settle();
      if (c < 2) begin
        check($sformatf("E_gnt%0d", c), 64'(d1_gnt), (c == 0) ? 64'h1 : 64'h0);
      end
      tick();
    end
    d1_req = 1'b0;
    settle();
    check("E_stall", 64'(d1_stall[0]), 64'(ExpStall));
    repeat (3) tick();
    check("E_stall_hold", 64'(d1_stall[0]), 64'(ExpStall));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
